vga_frame_writer: RTL and testbench
===================================

Name: vga_frame_writer

Overview:
- Avalon-MM write master that drives the VGA display peripheral's register file: boundary_1..4 at addresses 0-3, shift at 4, and sprite x/y/img at 5-13.
- Software or game logic pushes register-write commands into a queue, grouped into per-frame batches.
- The block replays exactly one complete batch per vertical-blanking window, so sprite and boundary updates never tear mid-frame.
- Sits between the command source and the display peripheral's Avalon slave port.

Parameters:
- ADDR_W, 6, Avalon address width.
- DATA_W, 16, Avalon writedata width.
- DEPTH, 32, command FIFO depth in entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_addr  in  ADDR_W  target register address
- cmd_data  in  DATA_W  register value
- cmd_last  in  1  final command of a frame batch
- vblank_in  in  1  high during vertical blanking; synchronous to clk
- avm_address  out  ADDR_W  Avalon address
- avm_writedata  out  DATA_W  Avalon write data
- avm_write  out  1  write request
- avm_chipselect  out  1  equal to avm_write
- avm_waitrequest  in  1  slave stall; tied 0 for the display peripheral
- busy  out  1  high while a batch is draining
- frames_done  out  8  count of completed batches, wraps 255->0
- late_pulse  out  1  one-cycle pulse when a batch finishes after vblank_in has fallen

Behaviour:
- Reset (asynchronous): FIFO empty, batch_cnt=0, FSM=IDLE, vblank_q=0. Outputs: avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, busy=0, frames_done=0, late_pulse=0, cmd_ready=1.
- FIFO entry format: {last, addr, data}.
- Push: occurs when cmd_valid && cmd_ready; cmd_ready = !full.
- Read: the FIFO head is read combinationally. avm_address and avm_writedata come from the head while in ISSUE, and are 0 otherwise.
- batch_cnt: width clog2(DEPTH)+1. Increments on a push with last=1 and decrements on a pop with last=1. If both happen in the same cycle, it is unchanged.
- vblank edge detect: vblank_q registers vblank_in each cycle; vb_rise = vblank_in && !vblank_q.
- FSM state IDLE:
  - On vb_rise && batch_cnt!=0, go to ISSUE.
  - A vb_rise with batch_cnt==0 is ignored. A batch completing later in the same blanking waits for the next vb_rise.
- FSM state ISSUE:
  - avm_write=1 and busy=1.
  - Address and data are held stable while avm_waitrequest=1.
  - A beat is accepted when avm_write && !avm_waitrequest; the head is then popped.
  - If the accepted entry has last=1, go to DONE; otherwise stay in ISSUE.
  - With waitrequest=0, throughput is 1 write per cycle.
- FSM state DONE (one cycle):
  - avm_write=0 and frames_done increments.
  - late_pulse=1 if vblank_in==0 in this cycle.
  - Return to IDLE.
- Latency: first avm_write is high 1 cycle after the cycle in which vb_rise is sampled true. A batch of N entries occupies N cycles of ISSUE plus 1 cycle of DONE.
- Batches are never torn: once ISSUE is entered, the batch drains to its last entry regardless of vblank_in.
- Push during drain: allowed. Entries pushed behind the current batch are not issued until a later vblank.
- FIFO full: cmd_ready=0 and the command source must hold its command.
- Full-FIFO deadlock: if the FIFO is full and contains no last entry, no batch can complete. Sources must bound batch length to at most DEPTH entries.
- Reset mid-burst: avm_write drops immediately (asynchronous reset) and all queued commands are discarded.

Decomposition:
- Package vga_frame_pkg contains:
  - Register address localparams: BOUND1..4=0..3, SHIFT=4, SPR1_X=5 ... SPR3_IMG=13.
  - cmd_t packed struct {last, addr, data}.
  - state_t enum {IDLE, ISSUE, DONE}.
- Sub-module vga_cmd_fifo: synchronous FIFO with parameterised DEPTH and width, combinational head output, and full/empty flags. It also holds batch_cnt bookkeeping.

Test Plan:
- Single batch:
  - Stimulus: push (0,100),(1,200),(4,1 last); vblank_in rises at cycle T; waitrequest=0.
  - Required: avm_write high in cycles T+1..T+3 with addresses 0,1,4 and data 100,200,1; frames_done=1 at T+5; busy low at T+4.
- Incomplete batch:
  - Stimulus: push 2 entries with no last; pulse vblank.
  - Required: no avm_write; then push (13,2 last); next vblank issues all 3 entries in order.
- Waitrequest stall:
  - Stimulus: hold waitrequest=1 for 4 cycles on the second beat.
  - Required: address/data stable for those cycles; no pop; total ISSUE cycles = 3+4.
- Back-to-back batches:
  - Stimulus: queue batches A (2 entries) and B (3 entries).
  - Required: first vblank issues only A; second vblank issues B; frames_done goes 1 then 2.
- Full FIFO and late finish:
  - Stimulus: fill DEPTH entries with last on entry DEPTH; drop vblank_in mid-drain.
  - Required: cmd_ready=0 while full; drain completes all DEPTH beats; late_pulse=1 for one cycle.
- Reset mid-burst:
  - Stimulus: assert reset while in ISSUE.
  - Required: avm_write=0 immediately; FIFO empty; frames_done=0; next vblank produces no writes.

Source files
------------

// File: rtl/vga_frame_pkg.sv
// Shared types and register map for the VGA frame writer.
// Register map of the display peripheral's Avalon slave.
package vga_frame_pkg;

  localparam logic [5:0] BOUND1   = 6'd0;
  localparam logic [5:0] BOUND2   = 6'd1;
  localparam logic [5:0] BOUND3   = 6'd2;
  localparam logic [5:0] BOUND4   = 6'd3;
  localparam logic [5:0] SHIFT    = 6'd4;
  localparam logic [5:0] SPR1_X   = 6'd5;
  localparam logic [5:0] SPR1_Y   = 6'd6;
  localparam logic [5:0] SPR1_IMG = 6'd7;
  localparam logic [5:0] SPR2_X   = 6'd8;
  localparam logic [5:0] SPR2_Y   = 6'd9;
  localparam logic [5:0] SPR2_IMG = 6'd10;
  localparam logic [5:0] SPR3_X   = 6'd11;
  localparam logic [5:0] SPR3_Y   = 6'd12;
  localparam logic [5:0] SPR3_IMG = 6'd13;

  // Command entry at the default bus widths; the top packs the same {last, addr, data} layout.
  typedef struct packed {
    logic        last;
    logic [5:0]  addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } state_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Command FIFO with combinational head and a count of complete batches held inside.
module vga_cmd_fifo #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] batch_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, batch_cnt_q;
  logic             do_push, do_pop, push_last, pop_last;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign head      = mem[rd_ptr_q[PTR_W-1:0]];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign push_last = do_push && wdata[WIDTH-1];
  assign pop_last  = do_pop && head[WIDTH-1];
  assign batch_cnt = batch_cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      batch_cnt_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      if (push_last && !pop_last)      batch_cnt_q <= batch_cnt_q + CNT_W'(1);
      else if (pop_last && !push_last) batch_cnt_q <= batch_cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// Avalon-MM write master replaying one queued register batch per vertical blanking.
module vga_frame_writer
  import vga_frame_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  input  logic              vblank_in,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_write,
  output logic              avm_chipselect,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [7:0]        frames_done,
  output logic              late_pulse
);

  localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;

  logic [CMD_W-1:0]        head;
  logic                    full, empty, push, pop, vb_rise, vblank_q;
  logic [$clog2(DEPTH):0]  batch_cnt;
  logic [7:0]              frames_q;
  state_t                  state_q, state_d;

  assign cmd_ready      = !full;
  assign push           = cmd_valid && cmd_ready;
  assign vb_rise        = vblank_in && !vblank_q;
  assign avm_chipselect = avm_write;
  assign frames_done    = frames_q;

  vga_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    ({cmd_last, cmd_addr, cmd_data}),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .batch_cnt(batch_cnt)
  );

  always_comb begin
    state_d       = state_q;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    busy          = 1'b0;
    pop           = 1'b0;
    late_pulse    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a fully queued batch is started; partial batches wait for a later blanking.
        if (vb_rise && batch_cnt != '0) state_d = StIssue;
      end
      StIssue: begin
        avm_write     = 1'b1;
        busy          = 1'b1;
        avm_address   = head[ADDR_W+DATA_W-1:DATA_W];
        avm_writedata = head[DATA_W-1:0];
        if (!avm_waitrequest && !empty) begin
          pop = 1'b1;
          if (head[CMD_W-1]) state_d = StDone;
        end
      end
      StDone: begin
        late_pulse = !vblank_in;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      vblank_q <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank_in;
      if (state_q == StDone) frames_q <= frames_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Scoreboard bench for vga_frame_writer: queued commands must come out as Avalon beats in order.
module tb_vga_frame_writer;
  import vga_frame_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_last;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        vblank_in;
  logic [5:0]  avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write, avm_chipselect, avm_waitrequest;
  logic        busy, late_pulse;
  logic [7:0]  frames_done;

  int   n_vec = 0;
  int   n_miss = 0;
  int   beats = 0;
  int   busy_cycles = 0;
  int   exp_frames = 0;
  cmd_t exp_q[$];

  vga_frame_writer #(
    .ADDR_W(6),
    .DATA_W(16),
    .DEPTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .cmd_last       (cmd_last),
    .vblank_in      (vblank_in),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_write      (avm_write),
    .avm_chipselect (avm_chipselect),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .frames_done    (frames_done),
    .late_pulse     (late_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int a, input int d, input int l);
    int n = 0;
    cmd_t c;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check_eq("push_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = 6'(a);
    cmd_data  = 16'(d);
    cmd_last  = 1'(l);
    c.last = 1'(l);
    c.addr = 6'(a);
    c.data = 16'(d);
    exp_q.push_back(c);
    step();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  // Beat monitor: every accepted write must match the oldest queued command.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (avm_write || avm_chipselect) check_eq("chipselect", 32'(avm_chipselect), 32'(avm_write));
      if (avm_write && !avm_waitrequest) begin
        beats++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_write", 32'(avm_write), 32'd0);
        end else begin
          cmd_t e;
          e = exp_q.pop_front();
          check_eq("beat_addr", 32'(avm_address), 32'(e.addr));
          check_eq("beat_data", 32'(avm_writedata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int b0, c0, late_cnt;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0;
    vblank_in = 1'b0; avm_waitrequest = 1'b0;
    #2;
    check_eq("rst_write", 32'(avm_write), 32'd0);
    check_eq("rst_cs", 32'(avm_chipselect), 32'd0);
    check_eq("rst_addr", 32'(avm_address), 32'd0);
    check_eq("rst_data", 32'(avm_writedata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frames", 32'(frames_done), 32'd0);
    check_eq("rst_late", 32'(late_pulse), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    step(); step();
    reset = 1'b0;
    step();

    // Single batch with cycle-exact timing.
    push_cmd(BOUND1, 100, 0);
    push_cmd(BOUND2, 200, 0);
    push_cmd(SHIFT, 1, 1);
    b0 = beats;
    vblank_in = 1'b1;
    @(negedge clk);
    check_eq("t0_write", 32'(avm_write), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("issue_write", 32'(avm_write), 32'd1);
      check_eq("issue_busy", 32'(busy), 32'd1);
      step();
    end
    @(negedge clk);
    check_eq("done_write", 32'(avm_write), 32'd0);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_late", 32'(late_pulse), 32'd0);
    check_eq("done_frames_pre", 32'(frames_done), 32'd0);
    step();
    exp_frames++;
    @(negedge clk);
    check_eq("single_frames", 32'(frames_done), 32'(exp_frames));
    check_eq("single_beats", 32'(beats - b0), 32'd3);
    step();
    vblank_in = 1'b0;
    step();

    // Incomplete batch is held until its last entry arrives.
    push_cmd(BOUND3, 7, 0);
    push_cmd(BOUND4, 8, 0);
    b0 = beats;
    vblank_in = 1'b1;
    repeat (4) step();
    vblank_in = 1'b0;
    step();
    check_eq("partial_beats", 32'(beats - b0), 32'd0);
    push_cmd(SPR3_IMG, 2, 1);
    vblank_in = 1'b1;
    repeat (6) step();
    exp_frames++;
    check_eq("partial_done_beats", 32'(beats - b0), 32'd3);
    check_eq("partial_frames", 32'(frames_done), 32'(exp_frames));
    vblank_in = 1'b0;
    step();

    // Waitrequest stall on the second beat.
    push_cmd(SPR1_X, 11, 0);
    push_cmd(SPR1_Y, 12, 0);
    push_cmd(SPR1_IMG, 13, 1);
    c0 = busy_cycles;
    vblank_in = 1'b1;
    step(); step();
    avm_waitrequest = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("stall_addr", 32'(avm_address), 32'(SPR1_Y));
      check_eq("stall_data", 32'(avm_writedata), 32'd12);
      step();
    end
    avm_waitrequest = 1'b0;
    repeat (4) step();
    exp_frames++;
    check_eq("stall_issue_cycles", 32'(busy_cycles - c0), 32'd7);
    check_eq("stall_frames", 32'(frames_done), 32'(exp_frames));
    vblank_in = 1'b0;
    step();

    // Two queued batches: one per blanking.
    push_cmd(SPR2_X, 1, 0);
    push_cmd(SPR2_Y, 2, 1);
    push_cmd(SPR2_IMG, 3, 0);
    push_cmd(SPR3_X, 4, 0);
    push_cmd(SPR3_Y, 5, 1);
    b0 = beats;
    vblank_in = 1'b1;
    repeat (6) step();
    exp_frames++;
    check_eq("b2b_a_beats", 32'(beats - b0), 32'd2);
    check_eq("b2b_a_frames", 32'(frames_done), 32'(exp_frames));
    vblank_in = 1'b0;
    step();
    vblank_in = 1'b1;
    repeat (6) step();
    exp_frames++;
    check_eq("b2b_b_beats", 32'(beats - b0), 32'd5);
    check_eq("b2b_b_frames", 32'(frames_done), 32'(exp_frames));
    vblank_in = 1'b0;
    step();

    // Full FIFO, drain outlasts the blanking window.
    for (int i = 0; i < 32; i++) push_cmd(i % 14, 1000 + i, (i == 31) ? 1 : 0);
    @(negedge clk);
    check_eq("full_ready", 32'(cmd_ready), 32'd0);
    step();
    b0 = beats;
    late_cnt = 0;
    vblank_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) vblank_in = 1'b0;
      @(negedge clk);
      if (late_pulse) late_cnt++;
      step();
    end
    exp_frames++;
    check_eq("full_beats", 32'(beats - b0), 32'd32);
    check_eq("late_count", 32'(late_cnt), 32'd1);
    check_eq("full_frames", 32'(frames_done), 32'(exp_frames));
    check_eq("drained_ready", 32'(cmd_ready), 32'd1);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst.
    push_cmd(BOUND1, 21, 0);
    push_cmd(BOUND2, 22, 0);
    push_cmd(BOUND3, 23, 0);
    push_cmd(BOUND4, 24, 1);
    vblank_in = 1'b1;
    step(); step();
    reset = 1'b1;
    #1;
    check_eq("rstmid_write", 32'(avm_write), 32'd0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_frames", 32'(frames_done), 32'd0);
    check_eq("rstmid_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    step();
    vblank_in = 1'b0;
    reset = 1'b0;
    step();
    b0 = beats;
    vblank_in = 1'b1;
    repeat (8) step();
    check_eq("post_rst_beats", 32'(beats - b0), 32'd0);
    check_eq("post_rst_frames", 32'(frames_done), 32'd0);
    vblank_in = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
